// File: rtl/prism_trace_pkg.sv
// Shared constants for the PRISM trace FIFO: register offsets, entry layout
// and STATUS/control bit positions.
package prism_trace_pkg;

    localparam logic [5:0] TRC_STATUS = 6'h00;
    localparam logic [5:0] TRC_DATA   = 6'h04;

    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned TS_LSB    = 11;

    localparam int unsigned ST_OVERFLOW  = 31;
    localparam int unsigned ST_DROP_LSB  = 16;
    localparam int unsigned ST_THR_LSB   = 8;
    localparam int unsigned ST_LEVEL_LSB = 4;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 0;

    localparam int unsigned CTL_CLR_OVF  = 31;
    localparam int unsigned CTL_FLUSH    = 30;

    typedef enum logic [1:0] {
        ACC_WORD = 2'b10,
        ACC_NONE = 2'b11
    } bus_acc_e;

endpackage

// File: rtl/prism_trace_mem.sv
// Flop-array FIFO storage for trace entries: pointers, level, full/empty, flush.
module prism_trace_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 27
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_r;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_r == '0);
    assign full    = (level_r == LVL_W'(DEPTH));
    assign level   = level_r;
    assign rd_data = mem[rd_ptr];

    // When full, a same-cycle pop frees the slot the push writes into.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/prism_trace_fifo.sv
// Observer of the PRISM output vector: logs each change with a saturating
// delta timestamp into a FIFO drained over the TinyQV peripheral bus.
module prism_trace_fifo
    import prism_trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 11,
    parameter int TS_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_en,
    input  logic                  trace_halt,
    input  logic [DATA_WIDTH-1:0] trace_data,
    input  logic                  sel,
    input  logic [5:0]            address,
    input  logic [31:0]           data_in,
    input  logic [1:0]            data_write_n,
    input  logic [1:0]            data_read_n,
    output logic [31:0]           data_out,
    output logic                  data_ready,
    output logic                  trace_irq
);
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] prev;
    logic [TS_WIDTH-1:0]   ts;
    logic                  en_r;
    logic                  overflow;
    logic [7:0]            drop_cnt;
    logic [3:0]            threshold;
    logic                  irq_r;

    logic [ENTRY_W-1:0]    head;
    logic [LVL_W-1:0]      level;
    logic                  full;
    logic                  empty;

    logic                  wr_status;
    logic                  rd_data_acc;
    logic                  clr_ovf;
    logic                  flush;
    logic                  baseline;
    logic                  capture;
    logic                  pop;
    logic                  drop;
    logic                  unused_data_in;

    assign data_ready = 1'b1;
    assign trace_irq  = irq_r;

    assign wr_status   = sel && (data_write_n == ACC_WORD) && (address == TRC_STATUS);
    assign rd_data_acc = sel && (data_read_n == ACC_WORD) && (address == TRC_DATA);
    assign clr_ovf     = wr_status & data_in[CTL_CLR_OVF];
    assign flush       = wr_status & data_in[CTL_FLUSH];
    assign unused_data_in = ^{data_in[29:12], data_in[7:0]};

    assign baseline = trace_en & ~en_r;
    assign capture  = trace_en & en_r & ~trace_halt & (trace_data != prev);
    assign pop      = rd_data_acc & ~empty;
    // A flushed push is discarded outright, not counted as a drop.
    assign drop     = capture & full & ~pop & ~flush;

    prism_trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (capture),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({ts, trace_data}),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            ts   <= '0;
            en_r <= 1'b0;
        end else begin
            en_r <= trace_en;
            if (baseline) begin
                prev <= trace_data;
                ts   <= '0;
            end else if (capture) begin
                prev <= trace_data;
                ts   <= '0;
            end else if (trace_en) begin
                ts <= (ts == '1) ? ts : ts + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            threshold <= '0;
            irq_r     <= 1'b0;
        end else begin
            if (wr_status) begin
                threshold <= data_in[ST_THR_LSB +: 4];
            end
            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= clr_ovf ? 8'd1
                          : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1);
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
            irq_r <= overflow | ((threshold != '0) && (32'(level) >= 32'(threshold)));
        end
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (address)
                TRC_STATUS: begin
                    data_out[ST_OVERFLOW]          = overflow;
                    data_out[ST_DROP_LSB +: 8]     = drop_cnt;
                    data_out[ST_THR_LSB +: 4]      = threshold;
                    data_out[ST_LEVEL_LSB +: 4]    = 4'(level);
                    data_out[ST_FULL]              = full;
                    data_out[ST_EMPTY]             = empty;
                end
                TRC_DATA: begin
                    if (!empty) begin
                        data_out[VALID_BIT]          = 1'b1;
                        data_out[TS_LSB +: TS_WIDTH] = head[DATA_WIDTH +: TS_WIDTH];
                        data_out[DATA_WIDTH-1:0]     = head[DATA_WIDTH-1:0];
                    end
                end
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_prism_trace_fifo.sv
// Directed bench for prism_trace_fifo: table-driven change/drain vectors plus
// hand-written sequences for the simultaneous-event corner cases.
module tb_prism_trace_fifo;

    localparam logic [5:0] A_STATUS = 6'h00;
    localparam logic [5:0] A_DATA   = 6'h04;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_en;
    logic        trace_halt;
    logic [10:0] trace_data;
    logic        sel;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        trace_irq;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int          gap;
        logic [10:0] value;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [9];

    prism_trace_fifo #(
        .DEPTH      (8),
        .DATA_WIDTH (11),
        .TS_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .trace_halt   (trace_halt),
        .trace_data   (trace_data),
        .sel          (sel),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .trace_irq    (trace_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string name, input logic [5:0] addr, input logic do_pop,
                              input logic [31:0] exp);
        sel         = 1'b1;
        address     = addr;
        data_read_n = do_pop ? 2'b10 : 2'b11;
        #1;
        check(name, data_out, exp);
        tick();
        sel         = 1'b0;
        address     = 6'h00;
        data_read_n = 2'b11;
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] d);
        sel          = 1'b1;
        address      = addr;
        data_in      = d;
        data_write_n = 2'b10;
        tick();
        sel          = 1'b0;
        data_in      = '0;
        data_write_n = 2'b11;
    endtask

    task automatic rebase();
        trace_en = 1'b0;
        tick();
        trace_en = 1'b1;
        tick();
    endtask

    task automatic change(input logic [10:0] v);
        trace_data = v;
        tick();
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'b0, trace_irq}, {31'b0, exp});
    endtask

    initial begin
        tbl[0] = '{0, 11'h001, 32'h80000001};
        tbl[1] = '{1, 11'h002, 32'h80000802};
        tbl[2] = '{2, 11'h004, 32'h80001004};
        tbl[3] = '{3, 11'h7FF, 32'h80001FFF};
        tbl[4] = '{0, 11'h400, 32'h80000400};
        tbl[5] = '{5, 11'h155, 32'h80002955};
        tbl[6] = '{0, 11'h2AA, 32'h800002AA};
        tbl[7] = '{7, 11'h0F0, 32'h800038F0};
        tbl[8] = '{0, 11'h00F, 32'h00000000};

        rst_n = 1'b0; trace_en = 1'b0; trace_halt = 1'b0; trace_data = '0;
        sel = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        repeat (3) tick();

        // reset state
        check("reset_dout_nosel", data_out, 32'h0);
        check_irq("reset_irq", 1'b0);
        check("data_ready", {31'b0, data_ready}, 32'h1);
        rst_n = 1'b1;
        tick();
        check_read("reset_status", A_STATUS, 1'b0, 32'h00000001);
        check_read("reset_data", A_DATA, 1'b0, 32'h00000000);

        // basic capture: 10 idle cycles after baseline
        trace_en = 1'b1;
        tick();
        repeat (10) tick();
        change(11'h005);
        check_read("basic_peek", A_DATA, 1'b0, 32'h80005005);
        check_read("basic_status", A_STATUS, 1'b0, 32'h00000010);
        check_read("basic_pop", A_DATA, 1'b1, 32'h80005005);
        check_read("basic_empty", A_STATUS, 1'b0, 32'h00000001);

        // halt: no capture, ts keeps counting
        rebase();
        trace_halt = 1'b1;
        trace_data = 11'h0F0;
        repeat (3) tick();
        check_read("halt_nocap", A_STATUS, 1'b0, 32'h00000001);
        trace_halt = 1'b0;
        tick();
        check_read("halt_entry", A_DATA, 1'b1, 32'h800020F0);

        // 9 changes into 8 entries: overflow, drain in order
        trace_data = 11'h000;
        rebase();
        for (int i = 0; i < 9; i++) begin
            repeat (tbl[i].gap) tick();
            change(tbl[i].value);
        end
        check_irq("ovf_irq_latency", 1'b0);
        check_read("ovf_status", A_STATUS, 1'b0, 32'h80010082);
        check_irq("ovf_irq", 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_read($sformatf("drain_%0d", i), A_DATA, 1'b1, tbl[i].exp_word);
        end
        check_read("drained_status", A_STATUS, 1'b0, 32'h80010001);
        bus_write(A_STATUS, 32'h80000000);
        check_read("ovf_cleared", A_STATUS, 1'b0, 32'h00000001);
        check_irq("ovf_irq_clear", 1'b0);

        // threshold interrupt
        bus_write(A_STATUS, 32'h00000300);
        rebase();
        change(11'h010);
        change(11'h011);
        change(11'h012);
        check_irq("thr_irq_pre", 1'b0);
        tick();
        check_irq("thr_irq_rise", 1'b1);
        check_read("thr_pop", A_DATA, 1'b1, 32'h80000010);
        check_irq("thr_irq_hold", 1'b1);
        tick();
        check_irq("thr_irq_drop", 1'b0);
        bus_write(A_STATUS, 32'h40000000);
        check_read("thr_flushed", A_STATUS, 1'b0, 32'h00000001);

        // full FIFO: pop and push in the same cycle
        rebase();
        for (int i = 0; i < 8; i++) change(11'h100 + 11'(i));
        check_read("full_status", A_STATUS, 1'b0, 32'h00000082);
        trace_data = 11'h1AA;
        check_read("full_pushpop", A_DATA, 1'b1, 32'h80000100);
        check_read("full_after", A_STATUS, 1'b0, 32'h00000082);
        check_irq("full_no_irq", 1'b0);
        for (int i = 1; i < 8; i++) begin
            check_read($sformatf("full_drain_%0d", i), A_DATA, 1'b1, 32'h80000100 + 32'(i));
        end
        check_read("full_newest", A_DATA, 1'b1, 32'h800009AA);
        check_read("full_empty", A_STATUS, 1'b0, 32'h00000001);

        // push and pop while empty
        rebase();
        trace_data = 11'h0AA;
        check_read("empty_pushpop", A_DATA, 1'b1, 32'h00000000);
        check_read("empty_pp_status", A_STATUS, 1'b0, 32'h00000010);
        check_read("empty_pp_entry", A_DATA, 1'b1, 32'h800000AA);

        // decode: ignored sizes, sel low, unmapped offset; flush beats push
        rebase();
        change(11'h011);
        sel = 1'b1; address = A_STATUS; data_in = 32'h40000000; data_write_n = 2'b00;
        tick();
        sel = 1'b0; data_in = '0; data_write_n = 2'b11;
        check_read("size_ignored", A_STATUS, 1'b0, 32'h00000010);
        address = A_DATA;
        #1;
        check("nosel_zero", data_out, 32'h0);
        check_read("unmapped_zero", 6'h08, 1'b0, 32'h00000000);
        trace_data = 11'h022;
        bus_write(A_STATUS, 32'h40000000);
        check_read("flush_status", A_STATUS, 1'b0, 32'h00000001);
        check_read("flush_data", A_DATA, 1'b0, 32'h00000000);
        tick();
        check_read("flush_prev", A_STATUS, 1'b0, 32'h00000001);

        // drop coinciding with overflow clear
        rebase();
        for (int i = 0; i < 10; i++) change(11'h200 + 11'(i));
        check_read("drop2_status", A_STATUS, 1'b0, 32'h80020082);
        trace_data = 11'h20A;
        bus_write(A_STATUS, 32'h80000000);
        check_read("drop_clr_status", A_STATUS, 1'b0, 32'h80010082);
        bus_write(A_STATUS, 32'hC0000000);
        check_read("drop_clr_flush", A_STATUS, 1'b0, 32'h00000001);

        // timestamp saturation
        rebase();
        repeat (70000) tick();
        change(11'h123);
        change(11'h124);
        check_read("ts_saturated", A_DATA, 1'b1, 32'h87FFF923);
        check_read("ts_restart", A_DATA, 1'b1, 32'h80000124);

        // asynchronous reset mid-operation
        change(11'h125);
        threshold_setup: begin
            bus_write(A_STATUS, 32'h00000100);
        end
        tick();
        check_irq("pre_reset_irq", 1'b1);
        #2;
        rst_n = 1'b0;
        sel = 1'b1; address = A_STATUS;
        #1;
        check("async_reset_status", data_out, 32'h00000001);
        check_irq("async_reset_irq", 1'b0);
        sel = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
